// File: rtl/sub_serial.sv
`timescale 1ns/1ps
// sub_serial: digit-serial W-bit unsigned subtractor (out = in0 - in1, borrow = in0 < in1).
// Processes D bits per clock through a registered borrow chain.
// Handshakes with valid/ready on both the input and the output side.
// Optional macro SUB_SERIAL_SAT_EN: when an underflow occurs, the result
// saturates to zero instead of wrapping.
module sub_serial #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         borrow
);

    localparam int NDIG = W / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_sh;
    logic          brw;

    logic [D:0]    digit;
    logic [W-1:0]  res_next;

`ifdef SUB_SERIAL_SAT_EN
    // Clamp an underflowed difference to zero; the borrow flag still reports it.
    function automatic logic [W-1:0] saturate(input logic [W-1:0] d, input logic b);
        return b ? '0 : d;
    endfunction
`endif

    // One digit of subtraction plus the result register after shifting the digit in at the top.
    always_comb begin
        digit    = {1'b0, a_sh[D-1:0]} - {1'b0, b_sh[D-1:0]} - {{D{1'b0}}, brw};
        res_next = W'({digit[D-1:0], res_sh} >> D);
    end

    // Only the idle state accepts a new operand pair.
    assign in_ready = (state == IDLE);

    // Control FSM with the operand/result shift registers and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            brw       <= 1'b0;
            out       <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= in0;
                        b_sh   <= in1;
                        res_sh <= '0;
                        brw    <= 1'b0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> D;
                    b_sh   <= b_sh >> D;
                    res_sh <= res_next;
                    brw    <= digit[D];
                    cnt    <= cnt + CW'(1);
                    // Last digit: publish the full difference in one step so partial results never show.
                    if (cnt == LAST) begin
`ifdef SUB_SERIAL_SAT_EN
                        out <= saturate(res_next, digit[D]);
`else
                        out <= res_next;
`endif
                        borrow    <= digit[D];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
`timescale 1ns/1ps
// Directed self-checking bench for sub_serial (W=8, D=2).
module tb_sub_serial;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       borrow;

    int tests;
    int fails;
    int cyc;

    sub_serial #(.W(8), .D(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in0      (in0),
        .in1      (in1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .borrow   (borrow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns number of edges waited.
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [7:0] exp_out(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
`ifdef SUB_SERIAL_SAT_EN
        if (a < b) d = 8'h00;
`endif
        return d;
    endfunction

    // Full transaction from IDLE: accept, check latency/result, transfer.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int k;
        in0 = a;
        in1 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_inrdy_busy"}, in_ready, 0);
        wait_valid(k);
        check({tag, "_latency"}, k, 4);
        check({tag, "_out"}, out, exp_out(a, b));
        check({tag, "_borrow"}, borrow, (a < b) ? 1 : 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, out_valid, 0);
    endtask

    logic [7:0] sa [8];
    logic [7:0] sb [8];

    initial begin
        int k;
        int acc;
        int prev;
        tests = 0;
        fails = 0;
        cyc = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in0 = 8'h00;
        in1 = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_borrow", borrow, 0);
        reset_n = 1'b1;
        tick();

        // Basic and boundary vectors
        do_op("basic", 8'h50, 8'h20);
        check("basic_hold_out", out, 8'h30);
        do_op("under", 8'h05, 8'h07);
        do_op("zero_ff", 8'h00, 8'hFF);
        do_op("ff_zero", 8'hFF, 8'h00);
        do_op("equal", 8'hA5, 8'hA5);
        do_op("ripple", 8'h80, 8'h01);

        // Backpressure: hold result in DONE while a new pair waits
        in0 = 8'h33;
        in1 = 8'h11;
        in_valid = 1'b1;
        tick();
        in0 = 8'h44;
        in1 = 8'h04;
        wait_valid(k);
        check("bp_latency", k, 4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_stable", out, 8'h22);
            check("bp_borrow_stable", borrow, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_xfer_vld", out_valid, 0);
        check("bp_xfer_out_kept", out, 8'h22);
        check("bp_xfer_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_new_accepted", in_ready, 0);
        wait_valid(k);
        check("bp_new_latency", k, 4);
        check("bp_new_out", out, 8'h40);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of BUSY
        in0 = 8'h9C;
        in1 = 8'h31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_borrow", borrow, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();
        do_op("after_rst", 8'h10, 8'h01);

        // Streaming with both handshakes held high
        for (int i = 0; i < 8; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
        end
        sa[3] = 8'h01;
        sb[3] = 8'hF0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            in0 = sa[i];
            in1 = sb[i];
            tick();
            acc = cyc;
            if (i > 0) check("stream_interval", acc - prev, 6);
            prev = acc;
            in0 = 8'h00;
            in1 = 8'h00;
            wait_valid(k);
            check("stream_latency", k, 4);
            check("stream_out", out, exp_out(sa[i], sb[i]));
            check("stream_borrow", borrow, (sa[i] < sb[i]) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
